// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the unified-bus memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2,
    DONE     = 2'd3
  } arbState_t;

  // Default number of BUSY cycles allowed before a transaction is aborted.
  localparam int DEFAULT_TIMEOUT = 255;

  // Width of the watchdog counter; wide enough for any legal TIMEOUT.
  localparam int WDOG_W = 16;

  // True while a transaction is outstanding on the bus.
  function automatic logic isBusy(arbState_t s);
    return (s == MEM_BUSY) || (s == IF_BUSY);
  endfunction

endpackage

// File: rtl/memory_arbiter_watchdog_counter.sv
// Watchdog for the arbiter: counts BUSY cycles and flags the last permitted one.
module watchdog_counter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count is zero in the first BUSY cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count;

  // Count enabled cycles, saturating at the last one; clear restarts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported unified memory bus between instruction fetch
// and the memory-stage data port; the data port has priority.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifRequest,
  input  logic [ADDR_W-1:0] ifAddress,
  output logic [DATA_W-1:0] ifInstruction,
  output logic              ifValid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] memAddress,
  input  logic [DATA_W-1:0] memWriteData,
  output logic [DATA_W-1:0] memReadData,
  output logic              memValid,
  output logic              busRequest,
  output logic              busWrite,
  output logic [ADDR_W-1:0] busAddress,
  output logic [DATA_W-1:0] busWriteData,
  input  logic [DATA_W-1:0] busReadData,
  input  logic              busReady,
  output logic              stallIf,
  output logic              stallPipeline,
  output logic              busError
);

  arbState_t state;
  arbState_t nextState;

  logic memRequest;
  logic busy;
  logic wdExpired;
  logic servedMem;   // 1 when the current/last transaction belongs to the data port

  assign memRequest = memRead | memWrite;
  assign busy       = isBusy(state);

  // Watchdog restarts whenever the bus is not busy, so each BUSY entry sees a zero count.
  watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) uWatchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~busy),
    .enable  (busy),
    .expired (wdExpired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: data port wins in IDLE; DONE always returns to IDLE so a
  // request still held by the advancing instruction is not re-issued.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (memRequest) begin
          nextState = MEM_BUSY;
        end else if (ifRequest) begin
          nextState = IF_BUSY;
        end
      end
      MEM_BUSY, IF_BUSY: begin
        if (busReady || wdExpired) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Bus registers: latched when a request is accepted in IDLE, held through BUSY.
  // A simultaneous read and write is issued as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      busAddress   <= '0;
      busWriteData <= '0;
      busWrite     <= 1'b0;
      servedMem    <= 1'b0;
    end else if (state == IDLE) begin
      if (memRequest) begin
        busAddress   <= memAddress;
        busWriteData <= memWriteData;
        busWrite     <= memWrite;
        servedMem    <= 1'b1;
      end else if (ifRequest) begin
        busAddress <= ifAddress;
        busWrite   <= 1'b0;
        servedMem  <= 1'b0;
      end
    end
  end

  // Result registers and sticky error: capture on busReady, zero-fill on timeout.
  // Stores complete without touching memReadData.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifInstruction <= '0;
      memReadData   <= '0;
      busError      <= 1'b0;
    end else if (busy) begin
      if (busReady) begin
        if (servedMem) begin
          if (!busWrite) begin
            memReadData <= busReadData;
          end
        end else begin
          ifInstruction <= busReadData;
        end
      end else if (wdExpired) begin
        busError <= 1'b1;
        if (servedMem) begin
          memReadData <= '0;
        end else begin
          ifInstruction <= '0;
        end
      end
    end
  end

  assign busRequest    = busy;
  assign memValid      = (state == DONE) &&  servedMem;
  assign ifValid       = (state == DONE) && !servedMem;
  assign stallPipeline = memRequest & ~memValid;
  assign stallIf       = stallPipeline | (ifRequest & ~ifValid);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for timeout and mid-transaction reset.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifRequest;
  logic [31:0] ifAddress;
  logic [31:0] ifInstruction;
  logic        ifValid;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memValid;
  logic        busRequest;
  logic        busWrite;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic [31:0] busReadData;
  logic        busReady;
  logic        stallIf;
  logic        stallPipeline;
  logic        busError;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ifRequest     (ifRequest),
    .ifAddress     (ifAddress),
    .ifInstruction (ifInstruction),
    .ifValid       (ifValid),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .memAddress    (memAddress),
    .memWriteData  (memWriteData),
    .memReadData   (memReadData),
    .memValid      (memValid),
    .busRequest    (busRequest),
    .busWrite      (busWrite),
    .busAddress    (busAddress),
    .busWriteData  (busWriteData),
    .busReadData   (busReadData),
    .busReady      (busReady),
    .stallIf       (stallIf),
    .stallPipeline (stallPipeline),
    .busError      (busError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        mRd;
    logic        mWr;
    logic [31:0] mAddr;
    logic [31:0] mWd;
    logic [31:0] bRd;
    logic        bRdy;
    logic        eReq;
    logic        eWr;
    logic [31:0] eAddr;
    logic [31:0] eWd;
    logic        eIfV;
    logic [31:0] eInstr;
    logic        eMemV;
    logic [31:0] eMemRd;
    logic        eStIf;
    logic        eStP;
    logic        eErr;
  } vec_t;

  vec_t vecs [23];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    ifRequest    = 1'b0;
    ifAddress    = 32'h0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = 32'h0;
    memWriteData = 32'h0;
    busReadData  = 32'h0;
    busReady     = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Fields: ifReq ifAddr mRd mWr mAddr mWd bRd bRdy | eReq eWr eAddr eWd eIfV eInstr eMemV eMemRd eStIf eStP eErr
    // Fetch 0x40, ready in first BUSY cycle
    vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'h20080005, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 32'h20080005, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 32'h20080005, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    // Simultaneous fetch and load 0x100, two wait states, then fetch after one IDLE cycle
    vecs[5]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 32'h20080005, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h20080005, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h20080005, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h11223344, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h20080005, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h20080005, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h20080005, 1'b0, 32'h11223344, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,        32'h8C090000, 1'b1, 1'b1, 1'b0, 32'h44,  32'h0,        1'b0, 32'h20080005, 1'b0, 32'h11223344, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h44,  32'h0,        1'b1, 32'h8C090000, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h44,  32'h0,        1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0};
    // Store 0x104 <- DEADBEEF, one wait state; bus data on store and in IDLE is ignored
    vecs[14] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h44,  32'h0,        1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h8C090000, 1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h55555555, 1'b1, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0};
    // Read and write together are issued as a write
    vecs[20] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h108, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h108, 32'h12345678, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b1, 32'h108, 32'h12345678, 1'b0, 32'h8C090000, 1'b0, 32'h11223344, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h108, 32'h12345678, 1'b0, 32'h8C090000, 1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0};

    idleInputs();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      ifRequest    = vecs[i].ifReq;
      ifAddress    = vecs[i].ifAddr;
      memRead      = vecs[i].mRd;
      memWrite     = vecs[i].mWr;
      memAddress   = vecs[i].mAddr;
      memWriteData = vecs[i].mWd;
      busReadData  = vecs[i].bRd;
      busReady     = vecs[i].bRdy;
      #1;
      check1 ($sformatf("v%0d busRequest", i),    busRequest,    vecs[i].eReq);
      check1 ($sformatf("v%0d busWrite", i),      busWrite,      vecs[i].eWr);
      check32($sformatf("v%0d busAddress", i),    busAddress,    vecs[i].eAddr);
      check32($sformatf("v%0d busWriteData", i),  busWriteData,  vecs[i].eWd);
      check1 ($sformatf("v%0d ifValid", i),       ifValid,       vecs[i].eIfV);
      check32($sformatf("v%0d ifInstruction", i), ifInstruction, vecs[i].eInstr);
      check1 ($sformatf("v%0d memValid", i),      memValid,      vecs[i].eMemV);
      check32($sformatf("v%0d memReadData", i),   memReadData,   vecs[i].eMemRd);
      check1 ($sformatf("v%0d stallIf", i),       stallIf,       vecs[i].eStIf);
      check1 ($sformatf("v%0d stallPipeline", i), stallPipeline, vecs[i].eStP);
      check1 ($sformatf("v%0d busError", i),      busError,      vecs[i].eErr);
      nextCycle();
    end

    // Timeout: load 0x200 with busReady held low for TIMEOUT=4 BUSY cycles
    idleInputs();
    memRead    = 1'b1;
    memAddress = 32'h200;
    #1;
    check1("to stallPipeline idle", stallPipeline, 1'b1);
    nextCycle();
    for (int c = 0; c < 4; c++) begin
      check1($sformatf("to busy%0d busRequest", c), busRequest, 1'b1);
      check1($sformatf("to busy%0d busError", c),   busError,   1'b0);
      check1($sformatf("to busy%0d memValid", c),   memValid,   1'b0);
      nextCycle();
    end
    check1 ("to done memValid",    memValid,    1'b1);
    check1 ("to done busError",    busError,    1'b1);
    check32("to done memReadData", memReadData, 32'h0);
    check1 ("to done busRequest",  busRequest,  1'b0);
    memRead = 1'b0;
    nextCycle();
    check1("to idle memValid", memValid, 1'b0);
    check1("to idle busError", busError, 1'b1);

    // busError stays set across a later successful read
    memRead    = 1'b1;
    memAddress = 32'h204;
    nextCycle();
    check1("rd2 busRequest", busRequest, 1'b1);
    busReady    = 1'b1;
    busReadData = 32'h0BADF00D;
    nextCycle();
    busReady = 1'b0;
    memRead  = 1'b0;
    #1;
    check1 ("rd2 memValid",    memValid,    1'b1);
    check32("rd2 memReadData", memReadData, 32'h0BADF00D);
    check1 ("rd2 busError",    busError,    1'b1);
    nextCycle();

    // Reset in MEM_BUSY abandons the transaction
    memRead    = 1'b1;
    memAddress = 32'h300;
    nextCycle();
    check1 ("rst busy busRequest", busRequest, 1'b1);
    check32("rst busy busAddress", busAddress, 32'h300);
    reset   = 1'b1;
    memRead = 1'b0;
    nextCycle();
    reset = 1'b0;
    #1;
    check1 ("rst busRequest",    busRequest,    1'b0);
    check1 ("rst busWrite",      busWrite,      1'b0);
    check32("rst busAddress",    busAddress,    32'h0);
    check32("rst busWriteData",  busWriteData,  32'h0);
    check32("rst memReadData",   memReadData,   32'h0);
    check32("rst ifInstruction", ifInstruction, 32'h0);
    check1 ("rst busError",      busError,      1'b0);
    check1 ("rst memValid",      memValid,      1'b0);
    check1 ("rst ifValid",       ifValid,       1'b0);

    // Fresh fetch after reset is served normally
    ifRequest = 1'b1;
    ifAddress = 32'h80;
    nextCycle();
    check1 ("post busRequest", busRequest, 1'b1);
    check32("post busAddress", busAddress, 32'h80);
    busReady    = 1'b1;
    busReadData = 32'h1234ABCD;
    nextCycle();
    busReady  = 1'b0;
    ifRequest = 1'b0;
    #1;
    check1 ("post ifValid",       ifValid,       1'b1);
    check32("post ifInstruction", ifInstruction, 32'h1234ABCD);
    nextCycle();
    check1("post ifValid drop", ifValid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
